// File: rtl/push_intr_arbiter.sv
// push_intr_arbiter
//    Push-button front end sharing one interrupt line between N_BTN buttons.
//    Each raw level is synchronised and debounced; a debounced press latches a
//    pending flag, and pending buttons are served round-robin through a level
//    interrupt with a one-cycle acknowledge. led_on counts serviced presses.
//
//    Build option: define PUSH_CNT_SAT_EN to make led_on saturate at all ones
//    instead of wrapping to zero.
//
//    state  | meaning
//    -------+--------------------------------------------------------------
//    IDLE   | no interrupt outstanding; grant next pending button if enabled
//    ASSERT | intr_src high with intr_id stable; waiting for intr_ack

module push_intr_arbiter #(
   parameter int N_BTN      = 4,
   parameter int ID_W       = 2,
   parameter int CNT_W      = 4,
   parameter int STABLE_CYC = 16
) (
   input  logic             S_AXI_ACLK,
   input  logic             S_AXI_ARESET,
   input  logic [N_BTN-1:0] push,
   input  logic             enable,
   input  logic             intr_ack,
   output logic             intr_src,
   output logic [ID_W-1:0]  intr_id,
   output logic [N_BTN-1:0] pending,
   output logic [CNT_W-1:0] led_on
);

   // Debounce counter only has to reach STABLE_CYC-1 before it is cleared.
   localparam int DB_W = $clog2(STABLE_CYC);
   localparam logic [DB_W-1:0] DB_TC    = DB_W'(STABLE_CYC - 1);
   localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_BTN - 1);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ASSERT = 1'b1;

   logic [N_BTN-1:0] sync_a;
   logic [N_BTN-1:0] sync_b;
   logic [N_BTN-1:0] db;
   logic [N_BTN-1:0] db_q;
   logic [DB_W-1:0]  db_cnt [N_BTN];
   logic [N_BTN-1:0] press;
   logic [N_BTN-1:0] pending_nxt;
   logic [0:0]       state;
   logic [ID_W-1:0]  last_grant;
   logic             grant_ok;
   logic [ID_W-1:0]  grant_idx;
   logic             ack_fire;
   logic [CNT_W-1:0] led_nxt;

   // Two-flop synchroniser for the asynchronous button levels.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= push;
         sync_b <= sync_a;
      end
   end

   // Per-button debounce: a new level is accepted only after it has differed
   // from the debounced level for STABLE_CYC consecutive cycles.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         db <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (sync_b[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_TC) begin
               db[i]     <= sync_b[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Delayed copy of the debounced level for rising-edge (press) detection.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         db_q <= '0;
      end else begin
         db_q <= db;
      end
   end

   // Only presses create events; releases are deliberately ignored.
   assign press    = db & ~db_q;
   assign ack_fire = (state == ST_ASSERT) && intr_ack;

   // Round-robin search: first pending bit after last_grant, wrapping.
   always_comb begin
      int               j;
      logic [ID_W-1:0]  cand;
      grant_ok  = 1'b0;
      grant_idx = last_grant;
      j         = 0;
      cand      = '0;
      for (int k = 1; k <= N_BTN; k++) begin
         j = int'(last_grant) + k;
         if (j >= N_BTN) begin
            j = j - N_BTN;
         end
         cand = ID_W'(j);
         if (!grant_ok && pending[cand]) begin
            grant_ok  = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Pending update: the acknowledge clears the served bit, and a press
   // landing on the same bit in the same cycle is applied last so it wins.
   always_comb begin
      pending_nxt = pending;
      if (ack_fire) begin
         pending_nxt[intr_id] = 1'b0;
      end
      pending_nxt = pending_nxt | press;
   end

   // Pending flag register; repeat presses on a set bit merge into it.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

`ifdef PUSH_CNT_SAT_EN
   assign led_nxt = (&led_on) ? led_on : led_on + 1'b1;
`else
   assign led_nxt = led_on + 1'b1;
`endif

   // Interrupt handshake FSM; returning to IDLE guarantees a low gap on
   // intr_src before the next grant.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         state      <= ST_IDLE;
         intr_src   <= 1'b0;
         intr_id    <= '0;
         last_grant <= LAST_RST;
         led_on     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable && grant_ok) begin
                  intr_id  <= grant_idx;
                  intr_src <= 1'b1;
                  state    <= ST_ASSERT;
               end
            end
            ST_ASSERT: begin
               if (intr_ack) begin
                  intr_src   <= 1'b0;
                  last_grant <= intr_id;
                  led_on     <= led_nxt;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               intr_src <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_push_intr_arbiter.sv
// Bench for push_intr_arbiter: debounce timing, round-robin service order,
// reset during a handshake, same-cycle set/clear and the enable gate.
module tb_push_intr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] push = '0;
   logic       enable = 1'b1;
   logic       intr_ack = 1'b0;
   logic       intr_src;
   logic [1:0] intr_id;
   logic [3:0] pending;
   logic [3:0] led_on;

   push_intr_arbiter #(
      .N_BTN(4), .ID_W(2), .CNT_W(4), .STABLE_CYC(16)
   ) dut (
      .S_AXI_ACLK  (clk),
      .S_AXI_ARESET(rst),
      .push        (push),
      .enable      (enable),
      .intr_ack    (intr_ack),
      .intr_src    (intr_src),
      .intr_id     (intr_id),
      .pending     (pending),
      .led_on      (led_on)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]      mask;
      int              n;
      logic [3:0][1:0] ids;
   } vec_t;

   int         checks = 0;
   int         failures = 0;
   int         exp_q[$];
   logic [3:0] exp_led = '0;
   vec_t       vecs[8];

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   function automatic logic [3:0] led_inc(logic [3:0] v);
`ifdef PUSH_CNT_SAT_EN
      return (v == 4'hF) ? v : v + 4'd1;
`else
      return v + 4'd1;
`endif
   endfunction

   function automatic vec_t mk(logic [3:0] mask, int n, logic [1:0] a,
                               logic [1:0] b, logic [1:0] c, logic [1:0] d);
      vec_t v;
      v.mask   = mask;
      v.n      = n;
      v.ids[0] = a;
      v.ids[1] = b;
      v.ids[2] = c;
      v.ids[3] = d;
      return v;
   endfunction

   task automatic wait_intr(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (intr_src) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL intr_timeout: intr_src=%0d after 80 cycles, required 1", intr_src);
      end
   endtask

   // Wait for the next interrupt, compare against the scoreboard, hold it
   // for a while with enable low, then acknowledge.
   task automatic serve_one(int hold);
      bit         ok;
      int         exp_id;
      logic [1:0] id0;
      wait_intr(ok);
      if (!ok) return;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_intr: got id %0d, required no interrupt", intr_id);
         return;
      end
      exp_id = exp_q.pop_front();
      check("intr_id", int'(intr_id), exp_id);
      id0 = intr_id;
      enable = 1'b0;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_src", int'(intr_src), 1);
         check("hold_id", int'(intr_id), int'(id0));
      end
      enable = 1'b1;
      intr_ack = 1'b1;
      tick();
      intr_ack = 1'b0;
      exp_led = led_inc(exp_led);
      check("ack_src_low", int'(intr_src), 0);
      check("led_on", int'(led_on), int'(exp_led));
   endtask

   task automatic run_vec(vec_t v);
      push = v.mask;
      for (int k = 0; k < v.n; k++) exp_q.push_back(int'(v.ids[k]));
      for (int k = 0; k < v.n; k++) serve_one(k % 3);
      check("pending_served", int'(pending), 0);
      push = '0;
      tick(25);
      check("queue_empty", exp_q.size(), 0);
      check("no_release_event", int'(pending), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int bad;

      vecs[0] = mk(4'b1000, 1, 2'd3, 2'd0, 2'd0, 2'd0);
      vecs[1] = mk(4'b1011, 3, 2'd0, 2'd1, 2'd3, 2'd0);
      vecs[2] = mk(4'b0001, 1, 2'd0, 2'd0, 2'd0, 2'd0);
      vecs[3] = mk(4'b0110, 2, 2'd1, 2'd2, 2'd0, 2'd0);
      vecs[4] = mk(4'b1111, 4, 2'd3, 2'd0, 2'd1, 2'd2);
      vecs[5] = mk(4'b0100, 1, 2'd2, 2'd0, 2'd0, 2'd0);
      vecs[6] = mk(4'b1001, 2, 2'd3, 2'd0, 2'd0, 2'd0);
      vecs[7] = mk(4'b0011, 2, 2'd1, 2'd0, 2'd0, 2'd0);

      // Reset values
      tick(3);
      check("rst_intr_src", int'(intr_src), 0);
      check("rst_intr_id", int'(intr_id), 0);
      check("rst_pending", int'(pending), 0);
      check("rst_led_on", int'(led_on), 0);
      rst = 1'b0;
      tick(2);

      // Short glitch on button 0 must be rejected
      push = 4'b0001;
      tick(10);
      push = '0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (pending != 4'b0000 || intr_src) bad++;
      end
      check("glitch_quiet", bad, 0);

      // Press latency: pending at edge 19, interrupt one cycle later
      push = 4'b0100;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (n == 18) check("lat_pending_early", int'(pending), 0);
         if (n == 19) begin
            check("lat_pending", int'(pending), 4);
            check("lat_src_early", int'(intr_src), 0);
         end
         if (n == 20) begin
            check("lat_src", int'(intr_src), 1);
            check("lat_id", int'(intr_id), 2);
         end
      end
      intr_ack = 1'b1;
      tick();
      intr_ack = 1'b0;
      exp_led = led_inc(exp_led);
      check("lat_ack_src", int'(intr_src), 0);
      check("lat_led", int'(led_on), int'(exp_led));
      push = '0;
      tick(25);

      // Reset in the middle of a handshake
      push = 4'b0010;
      wait_intr(ok);
      if (ok) check("pre_rst_id", int'(intr_id), 1);
      rst = 1'b1;
      #1;
      check("midrst_src", int'(intr_src), 0);
      check("midrst_pending", int'(pending), 0);
      check("midrst_led", int'(led_on), 0);
      check("midrst_id", int'(intr_id), 0);
      push = 4'b0011;
      tick(3);
      rst = 1'b0;
      exp_led = '0;
      exp_q.push_back(0);
      exp_q.push_back(1);
      serve_one(1);
      serve_one(0);
      push = '0;
      tick(25);

      // Round-robin vectors
      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Ack and a new press on the same bit in the same cycle
      push = 4'b0010;
      exp_q.push_back(1);
      wait_intr(ok);
      if (ok) check("sc_first_id", int'(intr_id), exp_q.pop_front());
      push = '0;
      tick(25);
      check("sc_still_asserted", int'(intr_src), 1);
      push = 4'b0010;
      tick(18);
      intr_ack = 1'b1;
      tick();
      intr_ack = 1'b0;
      exp_led = led_inc(exp_led);
      check("sc_src_gap", int'(intr_src), 0);
      check("sc_set_wins", int'(pending), 2);
      check("sc_led", int'(led_on), int'(exp_led));
      tick();
      check("sc_reissue_src", int'(intr_src), 1);
      check("sc_reissue_id", int'(intr_id), 1);
      exp_q.push_back(1);
      serve_one(0);
      push = '0;
      tick(25);
      check("sc_pending_clear", int'(pending), 0);

      // Enable gate and ack while idle
      enable = 1'b0;
      push = 4'b1000;
      tick(25);
      check("en_pending", int'(pending), 8);
      check("en_no_src", int'(intr_src), 0);
      intr_ack = 1'b1;
      tick();
      intr_ack = 1'b0;
      check("idle_ack_pending", int'(pending), 8);
      check("idle_ack_led", int'(led_on), int'(exp_led));
      tick(10);
      check("en_still_no_src", int'(intr_src), 0);
      enable = 1'b1;
      tick();
      check("en_src", int'(intr_src), 1);
      check("en_id", int'(intr_id), 3);
      exp_q.push_back(3);
      serve_one(0);
      push = '0;
      tick(25);

      check("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
